// File: rtl/uart_pkg.sv
// Shared definitions for the SoC serial receive path: FSM state encoding,
// data width and the default bit period.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 139;  // 115200 baud at 16 MHz

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so idle-high lines (UART) and other inputs can share it.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments make both stages sample the old values, giving a true two-flop shift.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, 1 stop bit, valid/ready byte output.
// Optional even-parity checking is compiled in with `define UART_RX_PARITY_EN;
// without it the frame is 8N1 and parity_err is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      uart_rxd,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun
);

    localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT);

    logic                      rxs;
    logic                      rxs_prev;
    logic                      fall;
    uart_rx_state_t            state, state_next;
    logic [CW-1:0]             cnt, cnt_next;
    logic [2:0]                idx, idx_next;
    logic [UART_DATA_BITS-1:0] shift, shift_next;
    logic                      expire;
    logic                      stop_sample;
    logic                      parity_bad;
    logic                      frame_evt;
    logic                      deliver;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (uart_rxd),
        .q     (rxs)
    );

    assign fall   = rxs_prev & ~rxs;
    assign expire = (cnt == CW'(1));

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_next;
    assign parity_bad = ^{shift, par_bit};
`else
    assign parity_bad = 1'b0;
`endif

    assign frame_evt = stop_sample & ~rxs;
    assign deliver   = stop_sample & rxs & ~parity_bad;

    // State register plus bit counter, bit index, shift register and edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            rxs_prev <= 1'b1;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            idx      <= idx_next;
            shift    <= shift_next;
            rxs_prev <= rxs;
        end
    end

    // Next-state logic: one shared counter times every bit, expiring at 1.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next  = state;
        cnt_next    = cnt;
        idx_next    = idx;
        shift_next  = shift;
        stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next    = par_bit;
`endif
        if (state != ST_IDLE) begin
            cnt_next = cnt - CW'(1);
        end

        case (state)
            ST_IDLE: begin
                if (fall) begin
                    cnt_next   = CNT_HALF;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (rxs) begin
                        state_next = ST_IDLE;   // glitch, not a start bit
                    end else begin
                        cnt_next   = CNT_FULL;
                        idx_next   = 3'd0;
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_next = {rxs, shift[UART_DATA_BITS-1:1]};
                    cnt_next   = CNT_FULL;
                    idx_next   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire) begin
                    par_next   = rxs;
                    cnt_next   = CNT_FULL;
                    state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expire) begin
                    stop_sample = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and mismatch pulse, reported with the stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_next;
            parity_err <= stop_sample & parity_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Output holding register, handshake and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= frame_evt;
            overrun   <= deliver & rx_valid & ~rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
